// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry output holding register.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial line (idle high, LSB first)
//   rx_data    received byte; stable while rx_valid is high
//   rx_valid   byte available; held until accepted
//   rx_ready   consumer accepts rx_data when rx_valid && rx_ready
//   frame_err  one-cycle pulse after a low stop bit
//   overrun    one-cycle pulse when a completed byte is dropped
//   busy       high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CPB  = CLK_FREQ / BAUD;
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned CW   = (CPB > 2) ? $clog2(CPB) : 1;

   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t        state;
   logic          sync1;
   logic          rx_s;
   logic          rx_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    bitn;
   logic [7:0]    shreg;
   // Stop-sample results, acted on one cycle later by the output stage.
   logic          done_ok;
   logic          done_bad;

   // Synchronizer, frame FSM and output holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         bitn      <= '0;
         shreg     <= '0;
         done_ok   <= 1'b0;
         done_bad  <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sync1     <= rx;
         rx_s      <= sync1;
         rx_prev   <= rx_s;
         done_ok   <= 1'b0;
         done_bad  <= 1'b0;
         frame_err <= done_bad;
         overrun   <= 1'b0;

         // A completing byte wins over a plain accept; an accept on the
         // same edge frees the slot so the new byte replaces the old one.
         if (done_ok) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rx_s && rx_prev) begin
                  state <= START;
                  cnt   <= '0;
                  bitn  <= '0;
                  busy  <= 1'b1;
               end
            end

            // Mid-start-bit check rejects short glitches silently.
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            DATA: begin
               if (cnt == CPB_M1) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  bitn  <= bitn + 3'd1;
                  if (bitn == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            // Re-arm straight into IDLE so back-to-back frames are caught.
            STOP: begin
               if (cnt == CPB_M1) begin
                  cnt <= '0;
                  if (rx_s) begin
                     done_ok <= 1'b1;
                     state   <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     done_bad <= 1'b1;
                     state    <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            // Swallow a break so it reports a single framing error.
            WAIT_HIGH: begin
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against uart_rx at 115200 baud
// on a 50 MHz clock, checked with immediate assertions.
module tb_uart_rx;

   localparam int unsigned CPB  = 434;
   localparam int unsigned HALF = 217;
   // Cycles from driving the start-bit edge to rx_valid/frame_err showing:
   // two synchronizer flops, one edge-detect cycle, the stop sample at
   // E+HALF+9*CPB, and one more edge for the output register.
   localparam int unsigned LAT  = 4 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int nvec = 0;
   int nerr = 0;

   int   cyc      = 0;
   int   nrise    = 0;
   int   rise_cyc = 0;
   int   nferr    = 0;
   int   ferr_cyc = 0;
   int   novr     = 0;
   logic pv       = 1'b0;

   always #10 clk = ~clk;

   uart_rx dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // Event recorder: cycle count, rx_valid rises and pulse counts.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rx_valid === 1'b1 && pv !== 1'b1) begin
         nrise++;
         rise_cyc = cyc;
      end
      pv = rx_valid;
      if (frame_err === 1'b1) begin
         nferr++;
         ferr_cyc = cyc;
      end
      if (overrun === 1'b1) novr++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one 8N1 frame; call on a falling clock edge. n = start cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int n);
      n  = cyc;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic accept();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n2, n0, r0, f0, o0, gap;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      bit got;

      rst = 1'b1;
      rx = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(rx_valid), 32'(0));
      check("rst_data", 32'(rx_data), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_ferr", 32'(frame_err), 32'(0));
      check("rst_ovr", 32'(overrun), 32'(0));
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Plain frame 0xB6.
      r0 = nrise; f0 = nferr;
      fork
         send_frame(8'hB6, 1'b1, n);
         begin
            repeat (3 * CPB) @(negedge clk);
            check("b6_busy_mid", 32'(busy), 32'(1));
         end
      join
      check("b6_data", 32'(rx_data), 32'(8'hB6));
      check("b6_valid", 32'(rx_valid), 32'(1));
      check("b6_rises", 32'(nrise - r0), 32'(1));
      check("b6_latency", 32'(rise_cyc - n), 32'(LAT));
      check("b6_ferr", 32'(nferr - f0), 32'(0));
      accept();
      check("b6_cleared", 32'(rx_valid), 32'(0));
      check("b6_data_kept", 32'(rx_data), 32'(8'hB6));
      repeat (CPB) @(negedge clk);

      // 3000 ns glitch on an idle line.
      r0 = nrise; f0 = nferr;
      n = cyc;
      rx = 1'b0;
      repeat (150) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_busy_start", 32'(busy), 32'(1));
      repeat (CPB - 190) @(negedge clk);
      check("glitch_idle", 32'(busy), 32'(0));
      while (cyc < n + int'(LAT) + 10) @(negedge clk);
      check("glitch_rises", 32'(nrise - r0), 32'(0));
      check("glitch_ferr", 32'(nferr - f0), 32'(0));

      // 0x55 with a low stop bit followed by a 20-bit break.
      r0 = nrise; f0 = nferr;
      send_frame(8'h55, 1'b0, n);
      repeat (20 * CPB) @(negedge clk);
      check("brk_busy_held", 32'(busy), 32'(1));
      check("brk_ferr_count", 32'(nferr - f0), 32'(1));
      check("brk_ferr_time", 32'(ferr_cyc - n), 32'(LAT));
      check("brk_rises", 32'(nrise - r0), 32'(0));
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("brk_busy_free", 32'(busy), 32'(0));
      check("brk_ferr_final", 32'(nferr - f0), 32'(1));
      repeat (CPB) @(negedge clk);

      // 0x01 then 0xFE back-to-back, nobody accepting.
      r0 = nrise; o0 = novr;
      send_frame(8'h01, 1'b1, n);
      send_frame(8'hFE, 1'b1, n2);
      check("ovr_data", 32'(rx_data), 32'(8'h01));
      check("ovr_valid", 32'(rx_valid), 32'(1));
      check("ovr_pulses", 32'(novr - o0), 32'(1));
      check("ovr_rises", 32'(nrise - r0), 32'(1));
      accept();
      check("ovr_cleared", 32'(rx_valid), 32'(0));
      check("ovr_data_kept", 32'(rx_data), 32'(8'h01));
      repeat (CPB) @(negedge clk);

      // 0xA5 then 0x3C, accept lands on the 0x3C completion edge.
      r0 = nrise; o0 = novr;
      n0 = cyc;
      fork
         begin
            send_frame(8'hA5, 1'b1, n);
            send_frame(8'h3C, 1'b1, n2);
         end
         begin
            repeat (10 * CPB + LAT - 1) @(negedge clk);
            check("same_edge_pre", 32'(rx_data), 32'(8'hA5));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            check("same_edge_data", 32'(rx_data), 32'(8'h3C));
            check("same_edge_valid", 32'(rx_valid), 32'(1));
         end
      join
      check("same_edge_start", 32'(n2 - n0), 32'(10 * CPB));
      check("same_edge_ovr", 32'(novr - o0), 32'(0));
      check("same_edge_rises", 32'(nrise - r0), 32'(1));
      accept();
      check("same_edge_cleared", 32'(rx_valid), 32'(0));
      repeat (CPB) @(negedge clk);

      // Reset during bit 4 of 0xFF, then a clean 0x42.
      r0 = nrise; f0 = nferr;
      fork
         send_frame(8'hFF, 1'b1, n);
         begin
            repeat (5 * CPB + 200) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_valid", 32'(rx_valid), 32'(0));
            check("midrst_data", 32'(rx_data), 32'(0));
            check("midrst_busy", 32'(busy), 32'(0));
            check("midrst_ferr", 32'(frame_err), 32'(0));
            check("midrst_ovr", 32'(overrun), 32'(0));
         end
      join
      repeat (CPB) @(negedge clk);
      check("midrst_rises", 32'(nrise - r0), 32'(0));
      check("midrst_nferr", 32'(nferr - f0), 32'(0));
      check("midrst_idle", 32'(busy), 32'(0));
      send_frame(8'h42, 1'b1, n);
      check("after_rst_data", 32'(rx_data), 32'(8'h42));
      check("after_rst_valid", 32'(rx_valid), 32'(1));
      check("after_rst_latency", 32'(rise_cyc - n), 32'(LAT));
      accept();
      repeat (CPB) @(negedge clk);

      // Random bytes with random idle gaps, consumed one by one.
      for (int k = 0; k < 3; k++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         gap = int'($urandom_range(1, CPB));
         repeat (gap) @(negedge clk);
         send_frame(b, 1'b1, n);
         got = 1'b0;
         for (int w = 0; w < 2 * int'(CPB) && !got; w++) begin
            if (rx_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
         end
         check("rand_valid", 32'(got), 32'(1));
         check("rand_data", 32'(rx_data), 32'(exp_q.pop_front()));
         accept();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
